// File: rtl/contador_seq_if.sv
// Host-side bundle for contador_seq: command handshake, early stop and result fields.
// The master drives commands; the slave (the sequencer) returns readiness and results.
interface contador_seq_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_modo;
  logic [3:0] cmd_D;
  logic [3:0] cmd_len;
  logic       stop;
  logic       busy;
  logic       done;
  logic [3:0] result_Q;
  logic [4:0] rco_count;
  logic       aborted;

  modport master (
    output cmd_valid, cmd_modo, cmd_D, cmd_len, stop,
    input  cmd_ready, busy, done, result_Q, rco_count, aborted
  );

  modport slave (
    input  cmd_valid, cmd_modo, cmd_D, cmd_len, stop,
    output cmd_ready, busy, done, result_Q, rco_count, aborted
  );
endinterface

// File: rtl/contador_seq.sv
// Command sequencer for the 4-bit up/down/load counter: runs one command for cmd_len+1
// enabled edges, counts rco pulses and returns the final count with a one-cycle done strobe.
module contador_seq (
  input  logic          clk,
  input  logic          reset,
  contador_seq_if.slave host,
  output logic          enable,
  output logic [1:0]    modo,
  output logic [3:0]    D,
  input  logic [3:0]    cnt_Q,
  input  logic          cnt_rco
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  remaining;
  logic        en_d;
  logic        done_r;
  logic [3:0]  result_q_r;
  logic [4:0]  rco_count_r;
  logic        aborted_r;
  logic [1:0]  modo_l;
  logic [3:0]  d_l;
  logic        cmd_ready_int;
  logic        accept;
  logic        run_last;

  assign cmd_ready_int = (state == S_IDLE) & ~reset;
  assign accept        = host.cmd_valid & cmd_ready_int;
  assign run_last      = (remaining == 4'd0) | host.stop;

  // Next state and counter-pin decode; pins depend only on registered state and latched fields
  always_comb begin
    state_nxt = state;
    enable    = 1'b0;
    modo      = 2'b00;
    D         = 4'd0;
    case (state)
      S_IDLE: begin
        if (accept) state_nxt = S_RUN;
      end
      S_RUN: begin
        enable = 1'b1;
        modo   = modo_l;
        D      = d_l;
        if (run_last) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      remaining   <= 4'd0;
      en_d        <= 1'b0;
      done_r      <= 1'b0;
      result_q_r  <= 4'd0;
      rco_count_r <= 5'd0;
      aborted_r   <= 1'b0;
    end else begin
      state  <= state_nxt;
      en_d   <= enable;
      done_r <= 1'b0;
      // rco reflects the previous enabled counter edge, so the last one lands in WAIT
      if (accept) begin
        remaining   <= host.cmd_len;
        rco_count_r <= 5'd0;
        aborted_r   <= 1'b0;
      end else if (en_d && cnt_rco) begin
        rco_count_r <= rco_count_r + 5'd1;
      end
      if (state == S_RUN) begin
        if (host.stop) aborted_r <= 1'b1;
        if (!run_last) remaining <= remaining - 4'd1;
      end
      if (state == S_WAIT) begin
        result_q_r <= cnt_Q;
        done_r     <= 1'b1;
      end
    end
  end

  // Command fields are data only; they are qualified by state and need no reset
  always_ff @(posedge clk) begin
    if (accept) begin
      modo_l <= host.cmd_modo;
      d_l    <= host.cmd_D;
    end
  end

  assign host.cmd_ready = cmd_ready_int;
  assign host.busy      = (state != S_IDLE);
  assign host.done      = done_r;
  assign host.result_Q  = result_q_r;
  assign host.rco_count = rco_count_r;
  assign host.aborted   = aborted_r;

endmodule
